// File: rtl/fruit_collision_scorer_pkg.sv
// Shared game package for the fruit collision scorer and related game logic.
// Holds the geometry constants for fruit and monkey boxes, the screen
// coordinate and score types, and the scorer FSM state encoding.
package fruit_collision_scorer_pkg;

    // Number of fruit slots scanned once per frame.
    localparam int NUM_FRUITS    = 5;

    // Bounding box sizes in pixels.
    localparam int FRUIT_WIDTH   = 32;
    localparam int FRUIT_HEIGHT  = 32;
    localparam int MONKEY_WIDTH  = 32;
    localparam int MONKEY_HEIGHT = 32;

    // Screen coordinates are signed so boxes may sit partly off-screen.
    localparam int COORD_W = 11;

    // Width of the fruit index used while scanning.
    localparam int IDX_W = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic        [15:0]        score_t;
    typedef logic        [IDX_W-1:0]   idx_t;

    // Scorer sequencing: wait for a frame, scan fruits one by one, report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam score_t SCORE_MAX = 16'hFFFF;

endpackage : fruit_collision_scorer_pkg

// File: rtl/fruit_collision_scorer_box_overlap.sv
// box_overlap: purely combinational axis-aligned bounding-box overlap test.
// Box A has its top-left corner at (a_x, a_y) and size A_WIDTH x A_HEIGHT,
// box B likewise. Edges that merely touch do not count as overlap.
// All comparisons are done in signed 12 bits so that negative or partly
// off-screen positions compare correctly without wrapping.
module box_overlap
    import fruit_collision_scorer_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int A_HEIGHT = 32,
    parameter int B_WIDTH  = 32,
    parameter int B_HEIGHT = 32
) (
    input  coord_t a_x,
    input  coord_t a_y,
    input  coord_t b_x,
    input  coord_t b_y,
    output logic   overlap
);

    localparam logic signed [COORD_W:0] A_W = (COORD_W+1)'(A_WIDTH);
    localparam logic signed [COORD_W:0] A_H = (COORD_W+1)'(A_HEIGHT);
    localparam logic signed [COORD_W:0] B_W = (COORD_W+1)'(B_WIDTH);
    localparam logic signed [COORD_W:0] B_H = (COORD_W+1)'(B_HEIGHT);

    logic signed [COORD_W:0] a_x_ext;
    logic signed [COORD_W:0] a_y_ext;
    logic signed [COORD_W:0] b_x_ext;
    logic signed [COORD_W:0] b_y_ext;
    logic                    overlap_x;
    logic                    overlap_y;

    // Sign-extend by one bit so that adding the box size can never wrap.
    always_comb begin
        a_x_ext = {a_x[COORD_W-1], a_x};
        a_y_ext = {a_y[COORD_W-1], a_y};
        b_x_ext = {b_x[COORD_W-1], b_x};
        b_y_ext = {b_y[COORD_W-1], b_y};
    end

    // Strict inequalities on both sides: sharing an edge is not a hit.
    always_comb begin
        overlap_x = (a_x_ext < (b_x_ext + B_W)) && (b_x_ext < (a_x_ext + A_W));
        overlap_y = (a_y_ext < (b_y_ext + B_H)) && (b_y_ext < (a_y_ext + A_H));
        overlap   = overlap_x && overlap_y;
    end

endmodule : box_overlap

// File: rtl/fruit_collision_scorer.sv
// fruit_collision_scorer: once per frame, snapshots the monkey and fruit
// positions, checks each visible fruit against the monkey one per cycle,
// then reports newly eaten fruits as a one-cycle mask and adds their points
// to a saturating running score. A fruit can only be credited once between
// resets, and allEaten latches once every slot has been credited.
//
// Optional build macro FRUIT_COMBO_EN: when defined, eating two or more
// fruits in the same frame adds COMBO_BONUS on top of the per-fruit points.
module fruit_collision_scorer
    import fruit_collision_scorer_pkg::*;
#(
    parameter int FRUIT_POINTS = 100
`ifdef FRUIT_COMBO_EN
    ,
    parameter int COMBO_BONUS  = 300
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  coord_t                    monkeyTopLeftX,
    input  coord_t                    monkeyTopLeftY,
    input  coord_t [NUM_FRUITS-1:0]   topLeftX,
    input  coord_t [NUM_FRUITS-1:0]   topLeftY,
    input  logic   [NUM_FRUITS-1:0]   drawFruit,
    output logic   [NUM_FRUITS-1:0]   monkeyCollision,
    output score_t                    score,
    output logic                      allEaten,
    output logic                      frameOverrun
);

    localparam idx_t IDX_LAST = idx_t'(NUM_FRUITS - 1);

    // Sequencing state.
    state_e                  state_q,     state_d;
    idx_t                    idx_q,       idx_d;

    // Per-frame snapshot of the inputs, so positions may change mid-scan.
    coord_t                  mon_x_q,     mon_x_d;
    coord_t                  mon_y_q,     mon_y_d;
    coord_t [NUM_FRUITS-1:0] fruit_x_q,   fruit_x_d;
    coord_t [NUM_FRUITS-1:0] fruit_y_q,   fruit_y_d;
    logic   [NUM_FRUITS-1:0] draw_q,      draw_d;

    // Hits found in the current frame and fruits credited since reset.
    logic   [NUM_FRUITS-1:0] hit_mask_q,  hit_mask_d;
    logic   [NUM_FRUITS-1:0] credited_q,  credited_d;

    // Registered outputs.
    logic   [NUM_FRUITS-1:0] collision_q, collision_d;
    score_t                  score_q,     score_d;
    logic                    all_eaten_q, all_eaten_d;
    logic                    overrun_q,   overrun_d;

    // Scan datapath.
    coord_t                  cur_fruit_x;
    coord_t                  cur_fruit_y;
    logic                    cur_overlap;
    logic                    scan_hit;

    // Score datapath.
    logic   [31:0]           hit_count;
    logic   [31:0]           frame_points;
    logic   [31:0]           score_sum;
    score_t                  score_next;

    // Select the fruit currently being examined from the snapshot.
    always_comb begin
        cur_fruit_x = fruit_x_q[idx_q];
        cur_fruit_y = fruit_y_q[idx_q];
    end

    box_overlap #(
        .A_WIDTH  (MONKEY_WIDTH),
        .A_HEIGHT (MONKEY_HEIGHT),
        .B_WIDTH  (FRUIT_WIDTH),
        .B_HEIGHT (FRUIT_HEIGHT)
    ) u_box_overlap (
        .a_x     (mon_x_q),
        .a_y     (mon_y_q),
        .b_x     (cur_fruit_x),
        .b_y     (cur_fruit_y),
        .overlap (cur_overlap)
    );

    // A fruit is eaten only if it is drawn, not yet credited, and overlaps.
    always_comb begin
        scan_hit = draw_q[idx_q] && !credited_q[idx_q] && cur_overlap;
    end

    // Points earned this frame, added to the score with saturation.
    always_comb begin
        hit_count    = 32'($countones(hit_mask_q));
        frame_points = hit_count * 32'(FRUIT_POINTS);
`ifdef FRUIT_COMBO_EN
        if (hit_count >= 32'd2) begin
            frame_points = frame_points + 32'(COMBO_BONUS);
        end
`endif
        score_sum = {16'd0, score_q} + frame_points;
        if (score_sum > {16'd0, SCORE_MAX}) begin
            score_next = SCORE_MAX;
        end else begin
            score_next = score_sum[15:0];
        end
    end

    // Next-state logic for the IDLE -> SCAN -> REPORT frame sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mon_x_d     = mon_x_q;
        mon_y_d     = mon_y_q;
        fruit_x_d   = fruit_x_q;
        fruit_y_d   = fruit_y_q;
        draw_d      = draw_q;
        hit_mask_d  = hit_mask_q;
        credited_d  = credited_q;
        collision_d = '0;
        score_d     = score_q;
        all_eaten_d = all_eaten_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (startOfFrame) begin
                    mon_x_d    = monkeyTopLeftX;
                    mon_y_d    = monkeyTopLeftY;
                    fruit_x_d  = topLeftX;
                    fruit_y_d  = topLeftY;
                    draw_d     = drawFruit;
                    hit_mask_d = '0;
                    idx_d      = '0;
                    state_d    = SCAN;
                end
            end

            SCAN: begin
                if (startOfFrame) begin
                    overrun_d = 1'b1;
                end
                if (scan_hit) begin
                    hit_mask_d[idx_q] = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    // The pulse register is loaded here so it is high
                    // exactly while the FSM sits in REPORT.
                    collision_d = hit_mask_d;
                    state_d     = REPORT;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end

            REPORT: begin
                if (startOfFrame) begin
                    overrun_d = 1'b1;
                end
                credited_d  = credited_q | hit_mask_q;
                score_d     = score_next;
                all_eaten_d = all_eaten_q | (&credited_d);
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mon_x_q     <= '0;
            mon_y_q     <= '0;
            fruit_x_q   <= '0;
            fruit_y_q   <= '0;
            draw_q      <= '0;
            hit_mask_q  <= '0;
            credited_q  <= '0;
            collision_q <= '0;
            score_q     <= '0;
            all_eaten_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mon_x_q     <= mon_x_d;
            mon_y_q     <= mon_y_d;
            fruit_x_q   <= fruit_x_d;
            fruit_y_q   <= fruit_y_d;
            draw_q      <= draw_d;
            hit_mask_q  <= hit_mask_d;
            credited_q  <= credited_d;
            collision_q <= collision_d;
            score_q     <= score_d;
            all_eaten_q <= all_eaten_d;
            overrun_q   <= overrun_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        monkeyCollision = collision_q;
        score           = score_q;
        allEaten        = all_eaten_q;
        frameOverrun    = overrun_q;
    end

endmodule : fruit_collision_scorer

// File: tb/tb_fruit_collision_scorer.sv
// Testbench for fruit_collision_scorer. Directed scenarios followed by
// randomized frames, all checked against a behavioural model that works on
// plain integer positions and a credited-fruit set.
module tb_fruit_collision_scorer;

    localparam int NF = 5;
    localparam int FW = 32;
    localparam int FH = 32;
    localparam int MW = 32;
    localparam int MH = 32;
    localparam int POINTS = 100;
    localparam int BONUS  = 300;

    logic                 clk;
    logic                 reset;
    logic                 startOfFrame;
    logic signed [10:0]   monkeyTopLeftX;
    logic signed [10:0]   monkeyTopLeftY;
    logic [NF-1:0][10:0]  topLeftX;
    logic [NF-1:0][10:0]  topLeftY;
    logic [NF-1:0]        drawFruit;
    logic [NF-1:0]        monkeyCollision;
    logic [15:0]          score;
    logic                 allEaten;
    logic                 frameOverrun;

    int total = 0;
    int bad   = 0;

    // Scenario description in plain integers.
    int          mdlMx;
    int          mdlMy;
    int          mdlFx [NF];
    int          mdlFy [NF];
    logic [NF-1:0] mdlDraw;

    // Reference state.
    logic [NF-1:0] mdlCredited;
    int            mdlScore;
    logic          mdlOverrun;

    fruit_collision_scorer dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .monkeyTopLeftX  (monkeyTopLeftX),
        .monkeyTopLeftY  (monkeyTopLeftY),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .drawFruit       (drawFruit),
        .monkeyCollision (monkeyCollision),
        .score           (score),
        .allEaten        (allEaten),
        .frameOverrun    (frameOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the model and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Eaten mask the scenario should produce, from the box rules directly.
    function automatic logic [NF-1:0] expectedMask();
        logic [NF-1:0] m;
        m = '0;
        for (int i = 0; i < NF; i++) begin
            if (mdlDraw[i] && !mdlCredited[i] &&
                (mdlMx < mdlFx[i] + FW) && (mdlFx[i] < mdlMx + MW) &&
                (mdlMy < mdlFy[i] + FH) && (mdlFy[i] < mdlMy + MH)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic driveScenario();
        monkeyTopLeftX = 11'(mdlMx);
        monkeyTopLeftY = 11'(mdlMy);
        for (int i = 0; i < NF; i++) begin
            topLeftX[i] = 11'(mdlFx[i]);
            topLeftY[i] = 11'(mdlFy[i]);
        end
        drawFruit = mdlDraw;
    endtask

    task automatic doReset();
        reset = 1'b1;
        startOfFrame = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdlCredited = '0;
        mdlScore    = 0;
        mdlOverrun  = 1'b0;
    endtask

    // Put all fruits far from everything.
    task automatic scatterFruits();
        for (int i = 0; i < NF; i++) begin
            mdlFx[i] = 900;
            mdlFy[i] = 600 + 40 * i - 200;
        end
        mdlDraw = '1;
    endtask

    // Run one frame: pulse startOfFrame, scramble inputs after the snapshot,
    // watch the pulse window, then compare score and flags with the model.
    task automatic applyStimulus(input string tag, input bit overrun);
        logic [NF-1:0] exp;
        int            cnt;
        exp = expectedMask();
        driveScenario();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        monkeyTopLeftX = 11'($urandom);
        monkeyTopLeftY = 11'($urandom);
        for (int i = 0; i < NF; i++) begin
            topLeftX[i] = 11'($urandom);
            topLeftY[i] = 11'($urandom);
        end
        drawFruit = NF'($urandom);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            // The REPORT cycle follows the fifth edge after the sampling edge.
            checkOutput({tag, "_collision"}, 32'(monkeyCollision),
                        (c == 5) ? 32'(exp) : 32'd0);
            if (overrun && c == 2) startOfFrame = 1'b1;
            if (overrun && c == 3) startOfFrame = 1'b0;
        end
        cnt = $countones(exp);
        mdlScore = mdlScore + cnt * POINTS;
`ifdef FRUIT_COMBO_EN
        if (cnt >= 2) mdlScore = mdlScore + BONUS;
`endif
        if (mdlScore > 65535) mdlScore = 65535;
        mdlCredited = mdlCredited | exp;
        if (overrun) mdlOverrun = 1'b1;
        checkOutput({tag, "_score"},    32'(score),        32'(mdlScore));
        checkOutput({tag, "_allEaten"}, 32'(allEaten),     32'(&mdlCredited));
        checkOutput({tag, "_overrun"},  32'(frameOverrun), 32'(mdlOverrun));
    endtask

    initial begin
        reset = 1'b1;
        startOfFrame = 1'b0;
        monkeyTopLeftX = '0;
        monkeyTopLeftY = '0;
        topLeftX = '0;
        topLeftY = '0;
        drawFruit = '0;
        #2;
        checkOutput("rst_collision", 32'(monkeyCollision), 32'd0);
        checkOutput("rst_score",     32'(score),           32'd0);
        checkOutput("rst_allEaten",  32'(allEaten),        32'd0);
        checkOutput("rst_overrun",   32'(frameOverrun),    32'd0);
        doReset();

        // Single fruit eaten, then repeated frames must not credit it again.
        scatterFruits();
        mdlMx = 100; mdlMy = 160;
        mdlFx[4] = 110; mdlFy[4] = 160;
        applyStimulus("single", 1'b0);
        checkOutput("single_score100", 32'(score), 32'd100);
        for (int f = 0; f < 3; f++) applyStimulus("repeat", 1'b0);

        // Touching edges are not a hit.
        doReset();
        scatterFruits();
        mdlMx = 0; mdlMy = 0;
        mdlFx[0] = 32; mdlFy[0] = 0;
        applyStimulus("edge", 1'b0);

        // Negative coordinates overlap.
        mdlMx = -10; mdlMy = 150;
        mdlFx[0] = -20; mdlFy[0] = 160;
        applyStimulus("negative", 1'b0);

        // Hidden fruit is never hit.
        doReset();
        scatterFruits();
        mdlMx = 300; mdlMy = 300;
        mdlFx[2] = 300; mdlFy[2] = 300;
        mdlDraw = 5'b11011;
        applyStimulus("hidden", 1'b0);

        // Two fruits in one frame, then the rest, until all are eaten.
        doReset();
        scatterFruits();
        mdlMx = 200; mdlMy = 200;
        mdlFx[0] = 210; mdlFy[0] = 190;
        mdlFx[1] = 180; mdlFy[1] = 215;
        applyStimulus("double", 1'b0);
        checkOutput("double_allEaten", 32'(allEaten), 32'd0);
        for (int i = 0; i < NF; i++) begin
            mdlFx[i] = 200; mdlFy[i] = 200;
        end
        applyStimulus("rest", 1'b0);
        checkOutput("rest_allEaten1", 32'(allEaten), 32'd1);

        // Second startOfFrame while busy.
        doReset();
        scatterFruits();
        mdlMx = 400; mdlMy = 100;
        mdlFx[3] = 420; mdlFy[3] = 80;
        applyStimulus("overrun", 1'b1);
        mdlFx[1] = 380; mdlFy[1] = 120;
        applyStimulus("after_overrun", 1'b0);

        // Randomized frames.
        doReset();
        for (int f = 0; f < 25; f++) begin
            mdlMx = int'($urandom_range(0, 700)) - 50;
            mdlMy = int'($urandom_range(0, 500)) - 50;
            for (int i = 0; i < NF; i++) begin
                mdlFx[i] = mdlMx + int'($urandom_range(0, 90)) - 45;
                mdlFy[i] = mdlMy + int'($urandom_range(0, 90)) - 45;
            end
            mdlDraw = NF'($urandom);
            applyStimulus("random", ($urandom_range(0, 4) == 0));
            if (f == 12) doReset();
        end

        // Reset during a scan aborts the frame and clears everything.
        doReset();
        scatterFruits();
        mdlMx = 50; mdlMy = 50;
        mdlFx[0] = 60; mdlFy[0] = 60;
        applyStimulus("prime", 1'b0);
        mdlFx[1] = 40; mdlFy[1] = 40;
        driveScenario();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_collision", 32'(monkeyCollision), 32'd0);
        checkOutput("midrst_score",     32'(score),           32'd0);
        checkOutput("midrst_allEaten",  32'(allEaten),        32'd0);
        checkOutput("midrst_overrun",   32'(frameOverrun),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_nopulse", 32'(monkeyCollision), 32'd0);
        end
        checkOutput("midrst_score_after", 32'(score), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_fruit_collision_scorer

// File: doc/fruit_collision_scorer.md
Name: fruit_collision_scorer

Overview:
- Sits directly downstream of the fruit placement stage. Consumes the per-fruit top-left positions and the drawFruit mask, plus the monkey's top-left position.
- Once per frame, scans the fruits sequentially for bounding-box overlap with the monkey. Feeds the resulting one-cycle monkeyCollision mask back to the fruit stage.
- Keeps the running game score and an all-fruits-eaten flag for the HUD and game-state logic.

Parameters:
- NUM_FRUITS, 5, number of fruit slots scanned per frame.
- FRUIT_WIDTH, 32, fruit box width in pixels.
- FRUIT_HEIGHT, 32, fruit box height in pixels.
- MONKEY_WIDTH, 32, monkey box width in pixels.
- MONKEY_HEIGHT, 32, monkey box height in pixels.
- FRUIT_POINTS, 100, score added per newly eaten fruit.
- COMBO_BONUS, 300, extra score for 2 or more fruits eaten in the same frame (only with the macro).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- monkeyTopLeftX  in  11 signed  monkey box left edge.
- monkeyTopLeftY  in  11 signed  monkey box top edge.
- topLeftX  in  NUM_FRUITS x 11 signed  fruit left edges.
- topLeftY  in  NUM_FRUITS x 11 signed  fruit top edges.
- drawFruit  in  NUM_FRUITS  fruit i is visible.
- monkeyCollision  out  NUM_FRUITS  one-cycle mask of fruits eaten this frame.
- score  out  16  running score, saturating.
- allEaten  out  1  every fruit slot has been credited.
- frameOverrun  out  1  sticky: startOfFrame arrived while busy.

Behaviour:
- Reset (async, active-high) values:
  - Outputs: monkeyCollision=0, score=0, allEaten=0, frameOverrun=0.
  - Internal: state=IDLE, idx=0, hitMask=0, creditedMask=0.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - On startOfFrame, snapshot monkeyTopLeftX/Y, topLeftX/Y and drawFruit into registers.
  - Clear hitMask, set idx=0, go to SCAN.
- SCAN, one fruit per cycle, idx 0..NUM_FRUITS-1:
  - hit = drawFruit[idx] && !creditedMask[idx] && overlapX && overlapY.
  - overlapX = (mx < fx+FRUIT_WIDTH) && (fx < mx+MONKEY_WIDTH). overlapY is the same form using the heights.
  - All arithmetic is signed 12-bit, so negative or partly off-screen boxes compare correctly. Touching edges (mx == fx+FRUIT_WIDTH) is not a hit.
  - On a hit, set hitMask[idx]. After idx=NUM_FRUITS-1, go to REPORT.
- REPORT, one cycle:
  - monkeyCollision is driven from hitMask for exactly this cycle. It is 0 in every other cycle.
  - creditedMask |= hitMask.
  - score += popcount(hitMask) x FRUIT_POINTS, saturating at 16'hFFFF.
  - Return to IDLE.
- Latency: if startOfFrame is sampled at edge k, SCAN occupies cycles k+1..k+NUM_FRUITS and monkeyCollision is high in cycle k+NUM_FRUITS+1 (k+6 at defaults).
- allEaten: registered; goes high the cycle after REPORT makes creditedMask all ones, and stays high until reset.
- startOfFrame while in SCAN or REPORT: ignored, sets frameOverrun. The snapshot is not disturbed and there is no restart.
- A fruit is credited at most once per reset, even if drawFruit stays high because the consumer has not yet cleared it.
- drawFruit=0 for a slot means it is never hit, whatever its position.
- Reset asserted mid-SCAN: aborts immediately, no pulse, score cleared.

Optional Feature:
- Macro FRUIT_COMBO_EN.
- Defined: in REPORT, if popcount(hitMask) >= 2, COMBO_BONUS is added on top of the per-fruit points in the same saturating add.
- Undefined: no bonus logic, and the COMBO_BONUS parameter is unused.

Decomposition:
- Shared game package holds:
  - NUM_FRUITS, FRUIT_WIDTH/HEIGHT, MONKEY_WIDTH/HEIGHT.
  - The screen-coordinate typedef: signed 11-bit.
  - The score typedef: 16-bit.
  - The FSM state enum.
- One natural sub-module, box_overlap: purely combinational signed AABB test, reusable for monkey-vs-enemy checks.

Test Plan:
- Reset, then monkey at (100,160), fruit 4 at (110,160), all drawFruit=1, one startOfFrame.
  - monkeyCollision=5'b10000 exactly 6 cycles later for one cycle; score=100.
- Same positions, startOfFrame repeated for 3 frames with drawFruit[4] held 1.
  - No further pulses; score stays 100 (creditedMask guard).
- Monkey at (0,0), fruit 0 at (32,0): edge-touch, so no hit, score 0.
- Monkey at (-10,150), fruit 0 at (-20,160): hit, covering negative coordinates.
- Fruits 0 and 1 both overlapping in one frame:
  - Mask 5'b00011.
  - score=200, or 500 with FRUIT_COMBO_EN.
  - After all five are credited, allEaten=1.
- startOfFrame pulsed 2 cycles after a previous one:
  - frameOverrun=1, and the first scan's result is unchanged.
- Separately, reset asserted during SCAN: no pulse, and all outputs are 0.
